pc_fetch_ctrl_rv32i: RTL and testbench

- Program-counter register and next-PC control for the single-issue RV32I core.
- Drives `PCold` into `pc_4_adder_rv32i` and instruction memory, and consumes the adder's `PC_4_inc` as the sequential next PC.
- Applies a fetch valid/ready handshake, stall, branch/jump redirect and halt.
- Keeps a fetch counter for debug.

---
 rtl/pc_fetch_ctrl_rv32i_if.sv | 47 ++++
 rtl/pc_fetch_ctrl_rv32i.sv | 93 +++++++++
 tb/tb_pc_fetch_ctrl_rv32i.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/pc_fetch_ctrl_rv32i_if.sv
// Fetch-controller bus: next-PC inputs, redirect/halt controls and the
// fetch handshake, plus the debug outputs. The master modport is the PC
// controller and the slave modport is the surrounding core/imem side.
interface pc_fetch_ctrl_rv32i_if;
    localparam int unsigned XLEN = 32;
    localparam int unsigned SW   = 2;

    logic [XLEN-1:0] PC_4_inc;
    logic            stall;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_target;
    logic            halt_req;
    logic            fetch_ready;
    logic [XLEN-1:0] PCold;
    logic            fetch_valid;
    logic            misalign;
    logic [SW-1:0]   fsm_state;
    logic [XLEN-1:0] fetch_count;

    modport master (
        input  PC_4_inc,
        input  stall,
        input  redirect_valid,
        input  redirect_target,
        input  halt_req,
        input  fetch_ready,
        output PCold,
        output fetch_valid,
        output misalign,
        output fsm_state,
        output fetch_count
    );

    modport slave (
        output PC_4_inc,
        output stall,
        output redirect_valid,
        output redirect_target,
        output halt_req,
        output fetch_ready,
        input  PCold,
        input  fetch_valid,
        input  misalign,
        input  fsm_state,
        input  fetch_count
    );
endinterface

// File: rtl/pc_fetch_ctrl_rv32i.sv
// Program-counter register and next-PC control for the RV32I fetch stage.
// BOOT -> RUN -> HALT state machine with stall, redirect, halt and a
// valid/ready fetch handshake; counts accepted fetches for debug.
// Optional feature macro: PC_MISALIGN_TRAP_EN (misaligned redirect traps
// to TRAP_VECTOR and sets a sticky misalign flag). When undefined, the low
// two redirect-target bits are cleared on load and misalign stays 0.
module pc_fetch_ctrl_rv32i #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
    input  logic                   clock,
    input  logic                   nreset,
    pc_fetch_ctrl_rv32i_if.master  bus
);
    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        ST_BOOT = 2'b00,
        ST_RUN  = 2'b01,
        ST_HALT = 2'b10
    } state_t;

    state_t          r_state;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_fetch_count;
    logic            r_misalign;

    logic            w_fetch_valid;
    logic            w_accept;
    logic            w_tgt_misaligned;
    logic [XLEN-1:0] w_tgt_aligned;
    logic [XLEN-1:0] w_redirect_pc;

    // Fetch is offered in RUN unless stalled; accepted on valid && ready
    assign w_fetch_valid = (r_state == ST_RUN) && !bus.stall;
    assign w_accept      = w_fetch_valid && bus.fetch_ready;

`ifdef PC_MISALIGN_TRAP_EN
    // Misaligned targets are diverted to the trap vector
    assign w_tgt_misaligned = |bus.redirect_target[1:0];
    assign w_tgt_aligned    = bus.redirect_target;
`else
    // Targets are forced word-aligned; nothing ever traps
    assign w_tgt_misaligned = 1'b0;
    assign w_tgt_aligned    = bus.redirect_target & ~XLEN'(3);
`endif

    assign w_redirect_pc = w_tgt_misaligned ? TRAP_VECTOR : w_tgt_aligned;

    // State machine, PC register, sticky misalign flag and fetch counter
    always_ff @(posedge clock) begin
        if (!nreset) begin
            r_state       <= ST_BOOT;
            r_pc          <= RESET_VECTOR;
            r_fetch_count <= '0;
            r_misalign    <= 1'b0;
        end else begin
            case (r_state)
                ST_BOOT: begin
                    r_state <= ST_RUN;
                end
                ST_RUN: begin
                    if (w_accept) begin
                        r_fetch_count <= r_fetch_count + XLEN'(1);
                    end
                    if (bus.halt_req) begin
                        r_state <= ST_HALT;
                    end else if (bus.redirect_valid) begin
                        r_pc <= w_redirect_pc;
                        if (w_tgt_misaligned) begin
                            r_misalign <= 1'b1;
                        end
                    end else if (w_accept) begin
                        r_pc <= bus.PC_4_inc;
                    end
                end
                ST_HALT: begin
                    r_state <= ST_HALT;
                end
                default: begin
                    r_state <= ST_BOOT;
                end
            endcase
        end
    end

    assign bus.PCold       = r_pc;
    assign bus.fetch_valid = w_fetch_valid;
    assign bus.misalign    = r_misalign;
    assign bus.fsm_state   = r_state;
    assign bus.fetch_count = r_fetch_count;

endmodule

// File: tb/tb_pc_fetch_ctrl_rv32i.sv
// Scoreboard bench for pc_fetch_ctrl_rv32i: the driver applies one directed
// vector per cycle and queues the outputs expected in that cycle; a monitor
// samples the DUT mid-cycle and compares against the queue head.
module tb_pc_fetch_ctrl_rv32i;
    localparam logic [1:0] S_BOOT = 2'b00;
    localparam logic [1:0] S_RUN  = 2'b01;
    localparam logic [1:0] S_HALT = 2'b10;

`ifdef PC_MISALIGN_TRAP_EN
    localparam logic [31:0] MIS_PC   = 32'h0000_0100;
    localparam logic        MIS_FLAG = 1'b1;
`else
    localparam logic [31:0] MIS_PC   = 32'h0000_0040;
    localparam logic        MIS_FLAG = 1'b0;
`endif

    typedef struct {
        logic [31:0] pc;
        logic        fv;
        logic        mis;
        logic [1:0]  st;
        logic [31:0] cnt;
        logic        chk;
        int          id;
    } exp_t;

    logic clk;
    logic nreset;
    int   checks;
    int   errors;
    int   vec_id;
    exp_t sb[$];

    pc_fetch_ctrl_rv32i_if bus ();

    pc_fetch_ctrl_rv32i dut (
        .clock  (clk),
        .nreset (nreset),
        .bus    (bus.master)
    );

    // External PC+4 adder
    assign bus.PC_4_inc = bus.PCold + 32'd4;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one vector at the falling edge and queue the expected outputs
    task automatic vec(input logic nr, input logic st_in, input logic rv,
                       input logic [31:0] rt, input logic hr, input logic fr,
                       input logic [31:0] e_pc, input logic e_fv, input logic e_mis,
                       input logic [1:0] e_st, input logic [31:0] e_cnt,
                       input logic chk);
        exp_t e;
        @(negedge clk);
        nreset              = nr;
        bus.stall           = st_in;
        bus.redirect_valid  = rv;
        bus.redirect_target = rt;
        bus.halt_req        = hr;
        bus.fetch_ready     = fr;
        e.pc  = e_pc;
        e.fv  = e_fv;
        e.mis = e_mis;
        e.st  = e_st;
        e.cnt = e_cnt;
        e.chk = chk;
        e.id  = vec_id;
        sb.push_back(e);
        vec_id++;
    endtask

    // Monitor: sample mid low-phase and compare with the scoreboard head
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                if (e.chk) begin
                    checks++;
                    if (bus.PCold !== e.pc) begin
                        errors++;
                        $display("FAIL vec%0d PCold: got %h expected %h", e.id, bus.PCold, e.pc);
                    end
                    checks++;
                    if (bus.fetch_valid !== e.fv) begin
                        errors++;
                        $display("FAIL vec%0d fetch_valid: got %b expected %b", e.id, bus.fetch_valid, e.fv);
                    end
                    checks++;
                    if (bus.misalign !== e.mis) begin
                        errors++;
                        $display("FAIL vec%0d misalign: got %b expected %b", e.id, bus.misalign, e.mis);
                    end
                    checks++;
                    if (bus.fsm_state !== e.st) begin
                        errors++;
                        $display("FAIL vec%0d fsm_state: got %b expected %b", e.id, bus.fsm_state, e.st);
                    end
                    checks++;
                    if (bus.fetch_count !== e.cnt) begin
                        errors++;
                        $display("FAIL vec%0d fetch_count: got %h expected %h", e.id, bus.fetch_count, e.cnt);
                    end
                end
            end
        end
    end

    // Directed stimulus: vec(nreset, stall, rv, target, halt, ready, exp pc, fv, mis, state, count, check)
    initial begin
        int wait_cycles;
        checks = 0;
        errors = 0;
        vec_id = 0;
        nreset = 1'b0;
        bus.stall = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_target = 32'h0;
        bus.halt_req = 1'b0;
        bus.fetch_ready = 1'b0;

        // Reset, BOOT for one cycle, then sequential fetch 0,4,8
        vec(0, 0, 0, 32'h0, 0, 0, 32'h0, 0, 0, S_BOOT, 32'd0, 0);
        vec(0, 0, 0, 32'h0, 0, 0, 32'h0, 0, 0, S_BOOT, 32'd0, 1);
        vec(1, 0, 0, 32'h0, 0, 1, 32'h0, 0, 0, S_BOOT, 32'd0, 1);
        vec(1, 0, 0, 32'h0, 0, 1, 32'h0, 1, 0, S_RUN,  32'd0, 1);
        vec(1, 0, 0, 32'h0, 0, 1, 32'h4, 1, 0, S_RUN,  32'd1, 1);
        // Not ready for three cycles at PC 8, then accept
        vec(1, 0, 0, 32'h0, 0, 0, 32'h8, 1, 0, S_RUN,  32'd2, 1);
        vec(1, 0, 0, 32'h0, 0, 0, 32'h8, 1, 0, S_RUN,  32'd2, 1);
        vec(1, 0, 0, 32'h0, 0, 0, 32'h8, 1, 0, S_RUN,  32'd2, 1);
        vec(1, 0, 0, 32'h0, 0, 1, 32'h8, 1, 0, S_RUN,  32'd2, 1);
        vec(1, 0, 0, 32'h0, 0, 1, 32'hC, 1, 0, S_RUN,  32'd3, 1);
        // Stall with redirect to 0x40: redirect wins, valid low while stalled
        vec(1, 1, 1, 32'h40, 0, 1, 32'h10, 0, 0, S_RUN, 32'd4, 1);
        vec(1, 1, 0, 32'h0,  0, 1, 32'h40, 0, 0, S_RUN, 32'd4, 1);
        vec(1, 0, 0, 32'h0,  0, 1, 32'h40, 1, 0, S_RUN, 32'd4, 1);
        // Redirect to FFFFFFFC with accept in the same cycle (counted)
        vec(1, 0, 1, 32'hFFFF_FFFC, 0, 1, 32'h44, 1, 0, S_RUN, 32'd5, 1);
        vec(1, 0, 0, 32'h0, 0, 1, 32'hFFFF_FFFC, 1, 0, S_RUN, 32'd6, 1);
        // Wrap to 0 with no flag, then misaligned redirect to 0x42
        vec(1, 0, 1, 32'h42, 0, 0, 32'h0, 1, 0, S_RUN, 32'd7, 1);
        vec(1, 0, 1, 32'h10, 0, 0, MIS_PC, 1, MIS_FLAG, S_RUN, 32'd7, 1);
        // Halt beats redirect at PC 0x10; HALT ignores all inputs
        vec(1, 0, 1, 32'h80, 1, 0, 32'h10, 1, MIS_FLAG, S_RUN,  32'd7, 1);
        vec(1, 0, 1, 32'h200, 0, 1, 32'h10, 0, MIS_FLAG, S_HALT, 32'd7, 1);
        vec(1, 1, 0, 32'h0,  1, 1, 32'h10, 0, MIS_FLAG, S_HALT, 32'd7, 1);
        // Reset for one edge returns to BOOT at RESET_VECTOR
        vec(0, 0, 0, 32'h0, 0, 1, 32'h10, 0, MIS_FLAG, S_HALT, 32'd7, 1);
        // BOOT ignores redirect, stall and halt
        vec(1, 1, 1, 32'h80, 1, 1, 32'h0, 0, 0, S_BOOT, 32'd0, 1);
        vec(1, 0, 0, 32'h0,  0, 1, 32'h0, 1, 0, S_RUN,  32'd0, 1);
        vec(1, 0, 0, 32'h0,  0, 0, 32'h4, 1, 0, S_RUN,  32'd1, 1);

        // Drain the scoreboard within a bounded number of cycles
        wait_cycles = 0;
        while (sb.size() > 0 && wait_cycles < 10) begin
            @(posedge clk);
            wait_cycles++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
